// File: rtl/aes_pkg.sv
// Shared AES-256 constants, types and GF(2^8) helpers for the encryption core.
package aes_pkg;

  localparam int NK  = 8;
  localparam int NR  = 14;
  localparam int NRK = NR + 1;
  localparam int NW  = 4 * NRK;

  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {IDLE, KEYEXP, ENC} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column is the most significant byte.
  function automatic word_t mix_column(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/encryption_core_standalone_spec.sv
// Iterative AES-256 encryptor: one schedule word per cycle during expansion,
// one full round per cycle during encryption.
module encryption_core_standalone_spec
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         key_start,
  input  logic [127:0] Plaintext,
  input  logic [255:0] Key,
  output logic [127:0] Ciphertext,
  output logic         finished,
  output logic         key_finished
);

  fsm_t       state_reg, state_next;
  state_t     data_reg;
  logic [3:0] round_reg;
  logic [5:0] widx_reg;
  word_t      sched [NW];

  logic   key_accept, start_accept;
  word_t  prev_word, back_word, sub_in, sub_out, temp_word, new_word;
  logic [2:0] rcon_idx;
  logic [7:0] sb_bytes [16];
  state_t sr_state, mc_state, round_key, rk0, round_out;
  logic [5:0] rk_base;

  // key_start beats start; nothing is accepted while a block is in flight.
  assign key_accept   = key_start && (state_reg != ENC);
  assign start_accept = (state_reg == IDLE) && start && key_finished && !key_start;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (key_start) state_next = KEYEXP;
               else if (start && key_finished) state_next = ENC;
      KEYEXP:  if (!key_start && widx_reg == 6'(NW)) state_next = IDLE;
      ENC:     if (round_reg == 4'(NR)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prev_word = sched[widx_reg - 6'd1];
  assign back_word = sched[widx_reg - 6'd8];
  assign sub_in    = (widx_reg[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
  assign rcon_idx  = widx_reg[5:3] - 3'd1;

  always_comb begin
    case (widx_reg[2:0])
      3'd0:    temp_word = sub_out ^ {RCON[rcon_idx], 24'h0};
      3'd4:    temp_word = sub_out;
      default: temp_word = prev_word;
    endcase
  end
  assign new_word = back_word ^ temp_word;

  assign rk_base = {round_reg, 2'b00};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
      aes_sbox u_sbox (.in_byte(sub_in[31-8*gi -: 8]), .out_byte(sub_out[31-8*gi -: 8]));
    end
    for (gi = 0; gi < 16; gi++) begin : g_sub
      aes_sbox u_sbox (.in_byte(data_reg[127-8*gi -: 8]), .out_byte(sb_bytes[gi]));
    end
    // Byte index is 4*column + row; row r rotates left by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int R = gi % 4;
      localparam int C = gi / 4;
      assign sr_state[127-8*gi -: 8] = sb_bytes[4*((C+R)%4) + R];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mc_state[127-32*gi -: 32]  = mix_column(sr_state[127-32*gi -: 32]);
      assign round_key[127-32*gi -: 32] = sched[rk_base + 6'(gi)];
      assign rk0[127-32*gi -: 32]       = sched[gi];
    end
  endgenerate

  assign round_out = ((round_reg == 4'(NR)) ? sr_state : mc_state) ^ round_key;

  // Schedule storage carries no reset; validity is tracked by key_finished.
  always_ff @(posedge CLK) begin
    if (key_accept) begin
      for (int i = 0; i < NK; i++) sched[i] <= Key[255-32*i -: 32];
    end else if (state_reg == KEYEXP && widx_reg != 6'(NW)) begin
      sched[widx_reg] <= new_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      round_reg    <= '0;
      widx_reg     <= '0;
      Ciphertext   <= '0;
      finished     <= 1'b0;
      key_finished <= 1'b0;
    end else begin
      state_reg <= state_next;
      finished  <= 1'b0;
      if (key_accept) begin
        widx_reg     <= 6'(NK);
        key_finished <= 1'b0;
      end else if (state_reg == KEYEXP) begin
        if (widx_reg == 6'(NW)) begin
          widx_reg     <= '0;
          key_finished <= 1'b1;
        end else begin
          widx_reg <= widx_reg + 6'd1;
        end
      end
      if (start_accept) begin
        data_reg  <= Plaintext ^ rk0;
        round_reg <= 4'd1;
      end else if (state_reg == ENC) begin
        data_reg <= round_out;
        if (round_reg == 4'(NR)) begin
          Ciphertext <= round_out;
          finished   <= 1'b1;
          round_reg  <= '0;
        end else begin
          round_reg <= round_reg + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encryption_core_standalone_spec.sv
// Scoreboard bench for the AES-256 core using FIPS-197 and SP800-38A vectors.
module tb_encryption_core_standalone_spec;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic         key_start = 1'b0;
  logic [127:0] Plaintext = '0;
  logic [255:0] Key = '0;
  logic [127:0] Ciphertext;
  logic         finished;
  logic         key_finished;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_F55 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_F0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CT_F0   = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] PT_F1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] CT_F1   = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] PT_F2   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
  localparam logic [127:0] CT_F2   = 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
  localparam logic [127:0] PT_F3   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
  localparam logic [127:0] CT_F3   = 128'h2956e1c8693536b1bee99c73a31576b6;

  encryption_core_standalone_spec dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .key_start    (key_start),
    .Plaintext    (Plaintext),
    .Key          (Key),
    .Ciphertext   (Ciphertext),
    .finished     (finished),
    .key_finished (key_finished)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Every finished pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (finished) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_finished cycle=%0d ct=%h required=no_pulse", cyc, Ciphertext);
      end else begin
        e = sb_q.pop_front();
        $display("txn block ct=%h expected=%h cycle=%0d due=%0d", Ciphertext, e.ct, cyc, e.due);
        if (Ciphertext !== e.ct) begin
          errors++;
          $display("FAIL ciphertext got=%h required=%h", Ciphertext, e.ct);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency got_cycle=%0d required_cycle=%0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct);
    start     = 1'b1;
    Plaintext = pt;
    sb_q.push_back('{ct, cyc + 15});
    step();
    start     = 1'b0;
    Plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", tag, sb_q.size());
      sb_q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    checks++;
    if (Ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ct got=%h required=0", Ciphertext); end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b required=0", finished); end
    checks++;
    if (key_finished !== 1'b0) begin errors++; $display("FAIL reset_kf got=%b required=0", key_finished); end
    step();
    RST = 1'b0;
    $display("txn reset released cycle=%0d", cyc);
  endtask

  task automatic test_no_key();
    start     = 1'b1;
    Plaintext = PT_C3;
    repeat (20) step();
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (Ciphertext !== 128'h0) begin errors++; $display("FAIL nokey_ct got=%h required=0", Ciphertext); end
    checks++;
    if (key_finished !== 1'b0) begin errors++; $display("FAIL nokey_kf got=%b required=0", key_finished); end
    step();
    $display("txn start_without_key ignored cycle=%0d", cyc);
  endtask

  task automatic test_key_expansion(input logic [255:0] k);
    key_start = 1'b1;
    Key       = k;
    step();
    key_start = 1'b0;
    Key       = {8{$urandom()}};
    @(negedge CLK);
    checks++;
    if (key_finished !== 1'b0) begin errors++; $display("FAIL kexp_cleared got=%b required=0", key_finished); end
    repeat (52) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (key_finished !== 1'b0) begin errors++; $display("FAIL kexp_early got=%b required=0 at 52", key_finished); end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (key_finished !== 1'b1) begin errors++; $display("FAIL kexp_done got=%b required=1 at 53", key_finished); end
    $display("txn key_expanded key=%h cycle=%0d", k, cyc);
    step();
  endtask

  task automatic test_c3();
    test_key_expansion(KEY_C3);
    run_block(PT_C3, CT_C3);
    wait_done("c3");
  endtask

  task automatic test_f55();
    test_key_expansion(KEY_F55);
    run_block(PT_F0, CT_F0);
    wait_done("f55");
  endtask

  task automatic test_back_to_back();
    int n = cyc;
    start     = 1'b1;
    Plaintext = PT_F1;
    sb_q.push_back('{CT_F1, n + 15});
    sb_q.push_back('{CT_F2, n + 30});
    sb_q.push_back('{CT_F3, n + 45});
    step();
    Plaintext = PT_F2;
    repeat (15) step();
    Plaintext = PT_F3;
    repeat (15) step();
    start     = 1'b0;
    Plaintext = '0;
    wait_done("b2b");
  endtask

  task automatic test_ignore_during_enc();
    run_block(PT_F0, CT_F0);
    repeat (3) step();
    start     = 1'b1;
    Plaintext = PT_C3;
    step();
    start = 1'b0;
    step();
    key_start = 1'b1;
    Key       = KEY_C3;
    step();
    key_start = 1'b0;
    wait_done("ignore");
    @(negedge CLK);
    checks++;
    if (key_finished !== 1'b1) begin errors++; $display("FAIL ignore_kf got=%b required=1", key_finished); end
    step();
    run_block(PT_F1, CT_F1);
    wait_done("oldkey");
  endtask

  task automatic test_reset_mid_enc();
    start     = 1'b1;
    Plaintext = PT_F0;
    step();
    start = 1'b0;
    repeat (6) step();
    RST = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (Ciphertext !== 128'h0) begin errors++; $display("FAIL midrst_ct got=%h required=0", Ciphertext); end
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL midrst_finished got=%b required=0", finished); end
    checks++;
    if (key_finished !== 1'b0) begin errors++; $display("FAIL midrst_kf got=%b required=0", key_finished); end
    step();
    RST = 1'b0;
    start = 1'b1;
    repeat (20) step();
    start = 1'b0;
    $display("txn reset_mid_enc aborted cycle=%0d", cyc);
    test_key_expansion(KEY_C3);
    run_block(PT_C3, CT_C3);
    wait_done("rerun");
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_c3();
    test_f55();
    test_back_to_back();
    test_ignore_during_enc();
    test_reset_mid_enc();
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encryption_core_standalone_spec.md
ENCRYPTION_CORE_STANDALONE_SPEC -- requirements
Module: encryption_core_standalone

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one block encryption; sampled on rising edge.
REQ-005 key_start  input  1  request key expansion of Key; sampled on rising edge.
REQ-006 Plaintext  input  128  input block, byte 0 = bits [127:120] (FIPS-197 order); captured when start is accepted.
REQ-007 Key  input  256  AES-256 cipher key, byte 0 = bits [255:248]; captured when key_start is accepted.
REQ-008 Ciphertext  output  128  result block, same byte order; registered, holds value until next completion.
REQ-009 finished  output  1  one-cycle pulse in the cycle Ciphertext first shows a new result.
REQ-010 key_finished  output  1  level; high while a valid expanded key schedule is stored.

Function
REQ-011 SHALL implement AES-256 encryption per FIPS-197 (Nk=8, Nr=14); decryption out of scope.
REQ-012 States: IDLE, KEYEXP, ENC.
REQ-013 IDLE + key_start=1 -> KEYEXP; latch Key as words w0..w7; clear key_finished.
REQ-014 KEYEXP computes one schedule word per cycle (w8..w59, 52 cycles), storing 15 round keys.
REQ-015 After w59 is written -> IDLE and key_finished=1; key_finished is set 53 cycles after the key_start edge.
REQ-016 key_start in KEYEXP restarts expansion with the currently presented Key.
REQ-017 IDLE + start=1 + key_finished=1 -> ENC; state = Plaintext XOR round key 0 in the same edge.
REQ-018 ENC performs one full round per cycle: rounds 1-13 SubBytes, ShiftRows, MixColumns, AddRoundKey; round 14 omits MixColumns.
REQ-019 Latency: Ciphertext valid and finished=1 exactly 14 cycles after the edge that accepted start; then -> IDLE.
REQ-020 start while key_finished=0, or while in KEYEXP/ENC, SHALL be ignored (no queueing).
REQ-021 key_start while in ENC SHALL be ignored; the current block completes with the old schedule.
REQ-022 start and key_start both high in IDLE: key_start wins; start is dropped.
REQ-023 start held high continuously SHALL start a new block on each return to IDLE (back-to-back blocks, no gap cycle required beyond IDLE).
REQ-024 Plaintext/Key changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-025 RST=1 at a rising edge -> IDLE, Ciphertext=0, finished=0, key_finished=0, round counters=0; stored schedule invalidated.
REQ-026 Reset mid-KEYEXP or mid-ENC aborts the operation; no finished/key_finished pulse is produced for it.
REQ-027 Behaviour before first reset is undefined; the bench SHALL assert RST for at least 2 cycles before stimulus.

Structure
REQ-028 Shared package aes_pkg: NK=8, NR=14, round-key count 15, Rcon table (10 bytes: 01,02,04,08,10,20,40,80,1b,36), typedef for 128-bit state and 32-bit word, GF(2^8) xtime function.
REQ-029 One sub-module aes_sbox (combinational 8-bit forward S-box); 16 instances for the datapath, 4 for key expansion.
REQ-030 Key schedule stored in a register array of 60 x 32-bit words; no memory macros.
REQ-031 Target size 120-400 RTL lines; no latches; single clock domain.

Verification
REQ-032 FIPS-197 C.3: Key 000102...1e1f, Plaintext 00112233445566778899aabbccddeeff -> Ciphertext 8ea2b7ca516745bfeafc49904b496089, finished 14 cycles after start.
REQ-033 SP800-38A F.5.5: Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, key_finished 53 cycles after key_start; Plaintext f0f1...feff -> 0bdf7df1591716335e9a8b15c860c502.
REQ-034 Same key, back-to-back blocks ...fdff00, ...fdff01, ...fdff02 -> 5a6e699d536119065433863c8f657b94, 1bc12c9c01610d5d0d8bd6a3378eca62, 2956e1c8693536b1bee99c73a31576b6; one finished pulse each.
REQ-035 start after reset with no key expanded -> no finished, Ciphertext stays 0; start during ENC -> ignored, single result.
REQ-036 RST asserted mid-ENC (cycle 7) -> all outputs 0 next cycle, key_finished=0; re-expand and re-run C.3 vector -> correct result.
